// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxBreak
  } rx_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO for the UART receiver; simultaneous push and pop always succeed.
module uart_rx_fifo #(
  parameter int unsigned Depth = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] data,
  output logic       valid,
  output logic       full
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push, do_pop;

  assign valid   = (count_q != '0);
  assign full    = (count_q == (PtrW + 1)'(Depth));
  assign do_pop  = pop & valid;
  // When full, a same-cycle pop frees the slot the push writes into.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

  assign data = valid ? mem_q[rptr_q] : 8'h00;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling FSM, and receive FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned DIV  = calc_div(CLK_HZ, BAUD);
  localparam int unsigned CntW = $clog2(DIV);
  localparam logic [CntW-1:0] HalfLoad = CntW'(DIV / 2 - 1);
  localparam logic [CntW-1:0] BitLoad  = CntW'(DIV - 1);

  if (DIV < 4) begin : g_div_check
    $error("uart_rx: bit period must be at least 4 clocks");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_rx: FIFO_DEPTH must be a power of two and at least 2");
  end

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      sync_q;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            rxs, tick, push, fifo_full;

  assign rxs  = sync_q[1];
  assign tick = (cnt_q == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q      <= 2'b11;
      state_q     <= RxIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rxd};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (!rxs) begin
          cnt_d   = HalfLoad;
          state_d = RxStart;
        end
      end
      RxStart: begin
        if (!tick) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (!rxs) begin
          cnt_d   = BitLoad;
          idx_d   = 3'd0;
          state_d = RxData;
        end else begin
          state_d = RxIdle;
        end
      end
      RxData: begin
        if (!tick) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          shift_d[idx_q] = rxs;
          cnt_d          = BitLoad;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = RxStop;
        end
      end
      RxStop: begin
        if (!tick) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (rxs) begin
          push    = 1'b1;
          state_d = RxIdle;
        end else begin
          frame_err_d = 1'b1;
          state_d     = RxBreak;
        end
      end
      RxBreak: begin
        if (rxs) state_d = RxIdle;
      end
      default: state_d = RxIdle;
    endcase
  end

  assign overrun_d = push & fifo_full & ~(rx_ack & rx_valid);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  uart_rx_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .nrst     (nrst),
    .push     (push),
    .push_data(shift_q),
    .pop      (rx_ack),
    .data     (rx_data),
    .valid    (rx_valid),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks/bit; received bytes are checked against a scoreboard queue.
module tb_uart_rx;

  localparam int unsigned ClkHz = 1_600_000;
  localparam int unsigned Baud  = 100_000;
  localparam int unsigned Depth = 16;
  localparam int unsigned Div   = 16;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;

  int total = 0;
  int bad = 0;
  int exp_ov = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic both_seen = 1'b0;
  logic long_seen = 1'b0;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;
  logic [7:0] sb [$];

  uart_rx #(
    .CLK_HZ    (ClkHz),
    .BAUD      (Baud),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts error pulses and flags overlap or stretched pulses.
  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (frame_err && overrun) both_seen <= 1'b1;
    if ((frame_err && fe_prev) || (overrun && ov_prev)) long_seen <= 1'b1;
    fe_prev <= frame_err;
    ov_prev <= overrun;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (Div) @(negedge clk);
  endtask

  // mode 0: plain frame; 1: pulse rx_ack in the stop-sample cycle; 2: check rx_valid rise timing.
  task automatic send(input logic [7:0] b, input logic stop_bit, input int mode);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    rxd = stop_bit;
    repeat (Div - 6) @(negedge clk);
    if (mode == 1) begin
      chk("valid_at_ack", rx_valid, 1);
      chk("head_at_ack", rx_data, sb[0]);
      rx_ack = 1'b1;
      void'(sb.pop_front());
    end
    if (mode == 2) chk("valid_before_stop", rx_valid, 0);
    @(negedge clk);
    rx_ack = 1'b0;
    if (mode == 2) chk("valid_after_stop", rx_valid, 1);
    repeat (5) @(negedge clk);
    if (stop_bit) begin
      if (sb.size() < Depth) sb.push_back(b);
      else exp_ov++;
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    e = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    chk({tag, "_valid"}, rx_valid, 1);
    chk(tag, rx_data, e);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte with rx_valid timing
    send(8'hA5, 1'b1, 2);
    pop_chk("a5");
    chk("a5_drained", rx_valid, 0);
    chk("a5_no_fe", fe_cnt, 0);
    chk("a5_no_ov", ov_cnt, 0);

    // Short low glitch is rejected
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_fe", fe_cnt, 0);
    chk("glitch_ov", ov_cnt, 0);

    // Framing error followed by a held break, then a good byte
    send(8'h3C, 1'b0, 0);
    repeat (40) @(negedge clk);
    chk("break_valid", rx_valid, 0);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    chk("fe_once", fe_cnt, 1);
    send(8'h55, 1'b1, 0);
    pop_chk("after_break");
    chk("after_break_drained", rx_valid, 0);
    chk("fe_still_once", fe_cnt, 1);

    // Fill past capacity
    for (int i = 0; i < 17; i++) send(8'(i), 1'b1, 0);
    chk("ov_on_17th", ov_cnt, exp_ov);
    chk("full_valid", rx_valid, 1);
    chk("fill_no_fe", fe_cnt, 1);

    // Push while full with a same-cycle pop
    send(8'h77, 1'b1, 1);
    chk("no_ov_with_pop", ov_cnt, exp_ov);
    for (int i = 0; i < 16; i++) pop_chk("drain");
    chk("drain_empty", rx_valid, 0);

    // Reset in the middle of a frame, with a byte already buffered
    send(8'h5A, 1'b1, 0);
    chk("pre_rst_valid", rx_valid, 1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (8) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_fe", frame_err, 0);
    chk("mid_rst_ov", overrun, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (Div * 6) @(negedge clk);
    chk("post_rst_idle", rx_valid, 0);
    send(8'h81, 1'b1, 0);
    pop_chk("post_rst");
    chk("post_rst_drained", rx_valid, 0);

    chk("fe_total", fe_cnt, 1);
    chk("ov_total", ov_cnt, exp_ov);
    chk("no_overlap", both_seen, 0);
    chk("no_long_pulse", long_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate in bits/s.
REQ-003 Parameter FIFO_DEPTH, default 16, receive buffer depth in bytes; power of two, >= 2.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 nrst  input  1  reset, asynchronous assert, active-low.
REQ-006 rxd  input  1  serial line, idle high, asynchronous to clk.
REQ-007 rx_data  output  8  head-of-buffer byte, valid while rx_valid=1 (show-ahead).
REQ-008 rx_valid  output  1  buffer non-empty.
REQ-009 rx_ack  input  1  pop head byte this cycle; ignored when rx_valid=0.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 overrun  output  1  one-cycle pulse: received byte dropped, buffer full.

Function
REQ-012 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-013 rxd SHALL pass through a 2-flop synchronizer; both flops reset to 1; all decisions use the synchronized value rxs.
REQ-014 Bit period DIV SHALL equal (CLK_HZ + BAUD/2) / BAUD, integer; elaboration SHALL fail if DIV < 4.
REQ-015 State machine SHALL have states IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE: on rxs=0, load counter with DIV/2 - 1, go START.
REQ-017 START: when counter reaches 0, sample rxs; 0 -> load DIV-1, bit index 0, go DATA; 1 -> go IDLE (glitch rejected, nothing reported).
REQ-018 DATA: each time counter reaches 0, shift rxs into bit[index], reload DIV-1; after index 7, go STOP.
REQ-019 STOP: when counter reaches 0, sample rxs; 1 -> push byte, go IDLE that cycle; 0 -> frame_err pulse, byte discarded, go BREAK.
REQ-020 BREAK: remain until rxs=1, then go IDLE; no start detected while in BREAK.
REQ-021 Push with buffer full and no same-cycle pop SHALL drop the new byte and pulse overrun; stored bytes unchanged.
REQ-022 Push and pop in same cycle SHALL both succeed, including when full; occupancy unchanged.
REQ-023 rx_valid SHALL rise the cycle after the stop-bit sample cycle when the buffer was empty.
REQ-024 Pop SHALL present the next byte on rx_data the following cycle; rx_data is don't-care when rx_valid=0.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-026 frame_err and overrun SHALL be registered, never asserted together, and never longer than 1 cycle per event.

Reset
REQ-027 nrst low SHALL asynchronously force: state IDLE, counter 0, bit index 0, shift register 0, buffer empty, rx_valid 0, rx_data 0, frame_err 0, overrun 0, synchronizer flops 1.
REQ-028 Reset mid-frame SHALL discard the partial byte; after release, reception restarts only on a fresh low level on rxs.

Structure
REQ-029 Shared package uart_pkg SHALL hold the rx state enum type and a DIV calculation function reused by uart_tx-side code.
REQ-030 The byte buffer SHALL be one sub-module, uart_rx_fifo (show-ahead, synchronous push/pop, same clk/nrst); the FSM, divider, and synchronizer stay in uart_rx.

Verification (CLK_HZ=1_600_000, BAUD=100_000, DIV=16, FIFO_DEPTH=16)
REQ-031 Send 0xA5 at 16 clk/bit -> rx_valid=1, rx_data=0xA5; rx_ack for 1 cycle -> rx_valid=0; no error pulses.
REQ-032 Drive rxd low for 4 cycles, then high -> FSM returns to IDLE; rx_valid, frame_err, overrun all stay 0.
REQ-033 Send 0x3C with stop bit 0, then hold rxd low 40 cycles, then send 0x55 -> one frame_err pulse; only 0x55 buffered.
REQ-034 Send 17 bytes 0x00..0x10, no rx_ack -> overrun pulses once on 17th; popping yields 0x00..0x0F in order.
REQ-035 With buffer full, assert rx_ack in the stop-sample cycle of an 18th byte 0x77 -> no overrun; 0x77 is last of 16 entries.
REQ-036 Assert nrst during data bit 4 of 0xFF, release, send 0x81 -> only 0x81 received; all outputs 0 during reset.
